// File: rtl/mem_port_arbiter.sv
// Round-robin front end that serialises instruction-fetch and load/store requests
// onto a single AXI-Lite master port, one transaction at a time.
module mem_port_arbiter #(
    parameter int AXI_AWIDTH = 32,
    parameter int AXI_DWIDTH = 32
) (
    input  logic                      AXI_ACLK,
    input  logic                      AXI_ARESETN,

    input  logic                      if_req,
    input  logic [AXI_AWIDTH-1:0]     if_addr,
    output logic [AXI_DWIDTH-1:0]     if_rdata,
    output logic                      if_done,
    output logic                      if_err,

    input  logic                      ls_req,
    input  logic                      ls_we,
    input  logic [AXI_AWIDTH-1:0]     ls_addr,
    input  logic [AXI_DWIDTH-1:0]     ls_wdata,
    input  logic [AXI_DWIDTH/8-1:0]   ls_wstrb,
    output logic [AXI_DWIDTH-1:0]     ls_rdata,
    output logic                      ls_done,
    output logic                      ls_err,

    output logic [AXI_AWIDTH-1:0]     AXI_AWADDR,
    output logic                      AXI_AWVALID,
    input  logic                      AXI_AWREADY,
    output logic [AXI_DWIDTH-1:0]     AXI_WDATA,
    output logic [AXI_DWIDTH/8-1:0]   AXI_WSTRB,
    output logic                      AXI_WVALID,
    input  logic                      AXI_WREADY,
    input  logic [1:0]                AXI_BRESP,
    input  logic                      AXI_BVALID,
    output logic                      AXI_BREADY,
    output logic [AXI_AWIDTH-1:0]     AXI_ARADDR,
    output logic                      AXI_ARVALID,
    input  logic                      AXI_ARREADY,
    input  logic [AXI_DWIDTH-1:0]     AXI_RDATA,
    input  logic [1:0]                AXI_RRESP,
    input  logic                      AXI_RVALID,
    output logic                      AXI_RREADY
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
    typedef enum logic {GNT_IF, GNT_LS} grant_t;

    state_t state_q, state_d;
    grant_t last_q, last_d;

    logic                    arvalid_q, arvalid_d, rready_q, rready_d;
    logic                    awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic                    ar_ok_q, ar_ok_d, aw_ok_q, aw_ok_d, w_ok_q, w_ok_d;
    logic [AXI_AWIDTH-1:0]   araddr_q, araddr_d, awaddr_q, awaddr_d;
    logic [AXI_DWIDTH-1:0]   wdata_q, wdata_d;
    logic [AXI_DWIDTH/8-1:0] wstrb_q, wstrb_d;
    logic [AXI_DWIDTH-1:0]   if_rdata_q, if_rdata_d, ls_rdata_q, ls_rdata_d;
    logic                    if_done_q, if_done_d, ls_done_q, ls_done_d;
    logic                    if_err_q, if_err_d, ls_err_q, ls_err_d;

    logic gnt_if, gnt_ls;
    logic ar_hs, rd_done, aw_hs, w_hs, wr_done;

    // On a tie the requester that did not win last time is granted
    assign gnt_if = if_req && (!ls_req || (last_q == GNT_LS));
    assign gnt_ls = ls_req && !gnt_if;

    assign ar_hs   = arvalid_q && AXI_ARREADY;
    assign rd_done = rready_q && AXI_RVALID && (ar_ok_q || ar_hs);
    assign aw_hs   = awvalid_q && AXI_AWREADY;
    assign w_hs    = wvalid_q && AXI_WREADY;
    assign wr_done = bready_q && AXI_BVALID && (aw_ok_q || aw_hs) && (w_ok_q || w_hs);

    always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
        if (!AXI_ARESETN) begin
            state_q <= IDLE;
            last_q  <= GNT_LS;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (gnt_if) begin
                    state_d = READ;
                    last_d  = GNT_IF;
                end else if (gnt_ls) begin
                    state_d = ls_we ? WRITE : READ;
                    last_d  = GNT_LS;
                end
            end
            READ:    if (rd_done) state_d = RESP;
            WRITE:   if (wr_done) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        arvalid_d  = arvalid_q;
        rready_d   = rready_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        bready_d   = bready_q;
        ar_ok_d    = ar_ok_q;
        aw_ok_d    = aw_ok_q;
        w_ok_d     = w_ok_q;
        araddr_d   = araddr_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        if_rdata_d = if_rdata_q;
        ls_rdata_d = ls_rdata_q;
        if_done_d  = 1'b0;
        ls_done_d  = 1'b0;
        if_err_d   = 1'b0;
        ls_err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (gnt_if || (gnt_ls && !ls_we)) begin
                    araddr_d  = gnt_if ? if_addr : ls_addr;
                    arvalid_d = 1'b1;
                    rready_d  = 1'b1;
                    ar_ok_d   = 1'b0;
                end else if (gnt_ls) begin
                    awaddr_d  = ls_addr;
                    wdata_d   = ls_wdata;
                    wstrb_d   = ls_wstrb;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    bready_d  = 1'b1;
                    aw_ok_d   = 1'b0;
                    w_ok_d    = 1'b0;
                end
            end
            READ: begin
                // ARVALID is withdrawn once accepted so a late RVALID cannot cause a second read
                if (ar_hs) begin
                    arvalid_d = 1'b0;
                    ar_ok_d   = 1'b1;
                end
                if (rd_done) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b0;
                    if (last_q == GNT_IF) begin
                        if_rdata_d = AXI_RDATA;
                        if_done_d  = 1'b1;
                        if_err_d   = (AXI_RRESP != 2'b00);
                    end else begin
                        ls_rdata_d = AXI_RDATA;
                        ls_done_d  = 1'b1;
                        ls_err_d   = (AXI_RRESP != 2'b00);
                    end
                end
            end
            WRITE: begin
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_ok_d   = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_ok_d   = 1'b1;
                end
                if (wr_done) begin
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b0;
                    bready_d  = 1'b0;
                    ls_done_d = 1'b1;
                    ls_err_d  = (AXI_BRESP != 2'b00);
                end
            end
            RESP:    ;
            default: ;
        endcase
    end

    always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
        if (!AXI_ARESETN) begin
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
            ar_ok_q    <= 1'b0;
            aw_ok_q    <= 1'b0;
            w_ok_q     <= 1'b0;
            araddr_q   <= '0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
            if_done_q  <= 1'b0;
            ls_done_q  <= 1'b0;
            if_err_q   <= 1'b0;
            ls_err_q   <= 1'b0;
        end else begin
            arvalid_q  <= arvalid_d;
            rready_q   <= rready_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            bready_q   <= bready_d;
            ar_ok_q    <= ar_ok_d;
            aw_ok_q    <= aw_ok_d;
            w_ok_q     <= w_ok_d;
            araddr_q   <= araddr_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            if_rdata_q <= if_rdata_d;
            ls_rdata_q <= ls_rdata_d;
            if_done_q  <= if_done_d;
            ls_done_q  <= ls_done_d;
            if_err_q   <= if_err_d;
            ls_err_q   <= ls_err_d;
        end
    end

    assign AXI_ARVALID = arvalid_q;
    assign AXI_RREADY  = rready_q;
    assign AXI_AWVALID = awvalid_q;
    assign AXI_WVALID  = wvalid_q;
    assign AXI_BREADY  = bready_q;
    assign AXI_ARADDR  = araddr_q;
    assign AXI_AWADDR  = awaddr_q;
    assign AXI_WDATA   = wdata_q;
    assign AXI_WSTRB   = wstrb_q;
    assign if_rdata    = if_rdata_q;
    assign ls_rdata    = ls_rdata_q;
    assign if_done     = if_done_q;
    assign ls_done     = ls_done_q;
    assign if_err      = if_err_q;
    assign ls_err      = ls_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: AXI-Lite memory slave plus a word-level memory and
// round-robin model that supply every expected value.
module tb_mem_port_arbiter;

    localparam logic [31:0] INIT [16] = '{
        32'h00000000, 32'h00500093, 32'h00000000, 32'h11223344,
        32'hDEADBEEF, 32'h0BADF00D, 32'h13579BDF, 32'h2468ACE0,
        32'hFFFFFFFF, 32'h01010101, 32'h80000001, 32'h7F7F7F7F,
        32'hCAFEBABE, 32'h55AA55AA, 32'h0F0F0F0F, 32'h12345678
    };

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req, ls_req, ls_we;
    logic [31:0] if_addr, ls_addr, ls_wdata;
    logic [3:0]  ls_wstrb;
    logic [31:0] if_rdata, ls_rdata;
    logic        if_done, if_err, ls_done, ls_err;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    logic [31:0] smem [16] = INIT;
    logic [31:0] rmem [16];
    logic        dec_mode = 1'b0;
    logic [1:0]  rresp_cfg = 2'b00;
    logic [1:0]  bresp_cfg = 2'b00;
    logic        wbusy;
    int          wt;

    int errors = 0;
    int checks = 0;
    bit m_last_ls;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AXI_AWIDTH(32), .AXI_DWIDTH(32)) dut (
        .AXI_ACLK(clk), .AXI_ARESETN(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done), .if_err(if_err),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_wstrb(ls_wstrb),
        .ls_rdata(ls_rdata), .ls_done(ls_done), .ls_err(ls_err),
        .AXI_AWADDR(awaddr), .AXI_AWVALID(awvalid), .AXI_AWREADY(awready),
        .AXI_WDATA(wdata), .AXI_WSTRB(wstrb), .AXI_WVALID(wvalid), .AXI_WREADY(wready),
        .AXI_BRESP(bresp), .AXI_BVALID(bvalid), .AXI_BREADY(bready),
        .AXI_ARADDR(araddr), .AXI_ARVALID(arvalid), .AXI_ARREADY(arready),
        .AXI_RDATA(rdata), .AXI_RRESP(rresp), .AXI_RVALID(rvalid), .AXI_RREADY(rready)
    );

    // Slave: read answers one cycle after ARVALID; write answers AW/W/B together,
    // or in dec_mode AWREADY first and WREADY+BVALID two cycles later.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arready <= 1'b0; rvalid <= 1'b0; rdata <= '0; rresp <= 2'b00;
            awready <= 1'b0; wready <= 1'b0; bvalid <= 1'b0; bresp <= 2'b00;
            wbusy <= 1'b0; wt <= 0;
        end else begin
            arready <= 1'b0; rvalid <= 1'b0; awready <= 1'b0; wready <= 1'b0;
            if (arvalid && rready && !arready) begin
                arready <= 1'b1; rvalid <= 1'b1;
                rdata <= smem[araddr[5:2]]; rresp <= rresp_cfg;
            end
            if (bvalid && bready) begin
                bvalid <= 1'b0; wbusy <= 1'b0;
            end else if (!wbusy && awvalid && wvalid) begin
                wbusy <= 1'b1; wt <= 1; awready <= 1'b1;
                if (!dec_mode) begin
                    wready <= 1'b1; bvalid <= 1'b1; bresp <= bresp_cfg;
                    for (int b = 0; b < 4; b++)
                        if (wstrb[b]) smem[awaddr[5:2]][8*b +: 8] <= wdata[8*b +: 8];
                end
            end else if (wbusy && dec_mode) begin
                wt <= wt + 1;
                if (wt == 2) begin
                    wready <= 1'b1; bvalid <= 1'b1; bresp <= bresp_cfg;
                    for (int b = 0; b < 4; b++)
                        if (wstrb[b]) smem[awaddr[5:2]][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] s);
        logic [31:0] m;
        m = '0;
        for (int b = 0; b < 4; b++) if (s[b]) m = m | (32'hFF << (8 * b));
        return (old & ~m) | (nw & m);
    endfunction

    // One transaction from a single requester; starts and ends on a negedge in IDLE.
    task automatic txn(input bit is_if, input bit we, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] strb,
                       input int exp_lat, output logic [31:0] got);
        int  k;
        bit  seen;
        bit  exp_err;
        got = '0;
        if (is_if) begin
            if_req = 1'b1; if_addr = addr;
        end else begin
            ls_req = 1'b1; ls_we = we; ls_addr = addr; ls_wdata = data; ls_wstrb = strb;
        end
        seen = 1'b0; k = 0;
        while (!seen && k < 40) begin
            @(negedge clk); k++;
            if (k == 1) begin
                if (we) begin
                    chk("aw_w_valid", 32'({awvalid, wvalid, arvalid}), 32'h6);
                    chk("awaddr", awaddr, addr);
                    chk("wdata", wdata, data);
                    chk("wstrb", 32'(wstrb), 32'(strb));
                end else begin
                    chk("ar_valid", 32'({arvalid, rready, awvalid, wvalid}), 32'hC);
                    chk("araddr", araddr, addr);
                end
            end
            if (if_done || ls_done) seen = 1'b1;
        end
        chk("done_timeout", 32'(seen), 32'd1);
        if (seen) begin
            chk("done_port", 32'({if_done, ls_done}), is_if ? 32'h2 : 32'h1);
            if (exp_lat > 0) chk("latency", 32'(k), 32'(exp_lat));
            exp_err = we ? (bresp_cfg != 2'b00) : (rresp_cfg != 2'b00);
            chk("err", 32'(is_if ? if_err : ls_err), 32'(exp_err));
            chk("chan_idle", 32'({arvalid, rready, awvalid, wvalid, bready}), 32'h0);
            if (!we) begin
                got = is_if ? if_rdata : ls_rdata;
                chk("rdata", got, rmem[addr[5:2]]);
            end
            m_last_ls = !is_if;
        end
        if (we) rmem[addr[5:2]] = merge(rmem[addr[5:2]], data, strb);
        if_req = 1'b0; ls_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] got, a_if, a_ls, d;
        logic [3:0]  idx, s;
        logic [1:0]  lo;
        int          n, k, kind;
        bit          saw_split, saw_b, early_done, seen, bad_done;
        logic [1:0]  exp_pick;

        rmem = INIT;
        if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
        if_addr = '0; ls_addr = '0; ls_wdata = '0; ls_wstrb = '0;

        repeat (2) @(negedge clk);
        chk("rst_valids", 32'({arvalid, rready, awvalid, wvalid, bready}), 32'h0);
        chk("rst_done_err", 32'({if_done, ls_done, if_err, ls_err}), 32'h0);
        chk("rst_rdata", if_rdata | ls_rdata, 32'h0);
        chk("rst_addr", awaddr | araddr, 32'h0);
        chk("rst_wdata_wstrb", wdata | 32'(wstrb), 32'h0);
        rst_n = 1'b1;
        m_last_ls = 1'b1;
        @(negedge clk);

        txn(1'b1, 1'b0, 32'd4, '0, '0, 3, got);
        chk("if_read_word1", got, 32'h00500093);

        txn(1'b0, 1'b1, 32'd8, 32'hAABBCCDD, 4'b0101, 3, got);
        txn(1'b0, 1'b0, 32'd8, '0, '0, 3, got);
        chk("ls_strobe_merge", got, 32'h00BB00DD);

        // Both requests held continuously for three transactions
        a_if = 32'd12; a_ls = 32'd16;
        if_req = 1'b1; if_addr = a_if;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = a_ls;
        n = 0; k = 0;
        while (n < 3 && k < 60) begin
            @(negedge clk); k++;
            if (if_done || ls_done) begin
                exp_pick = m_last_ls ? 2'b10 : 2'b01;
                chk("rr_order", 32'({if_done, ls_done}), 32'(exp_pick));
                if (exp_pick == 2'b10) chk("rr_if_rdata", if_rdata, rmem[a_if[5:2]]);
                else                   chk("rr_ls_rdata", ls_rdata, rmem[a_ls[5:2]]);
                m_last_ls = (exp_pick == 2'b01);
                n++;
            end
        end
        chk("rr_done_count", 32'(n), 32'd3);
        if_req = 1'b0; ls_req = 1'b0;
        @(negedge clk);

        // AWREADY arrives two cycles ahead of WREADY/BVALID
        dec_mode = 1'b1;
        d = $urandom;
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'd20; ls_wdata = d; ls_wstrb = 4'hF;
        saw_split = 1'b0; saw_b = 1'b0; early_done = 1'b0; seen = 1'b0; k = 0;
        while (!seen && k < 40) begin
            @(negedge clk); k++;
            if (ls_done) begin
                seen = 1'b1;
                if (!saw_b) early_done = 1'b1;
            end
            if (awvalid == 1'b0 && wvalid == 1'b1) saw_split = 1'b1;
            if (bvalid) saw_b = 1'b1;
        end
        chk("dec_done_seen", 32'(seen), 32'd1);
        chk("dec_aw_drop_w_high", 32'(saw_split), 32'd1);
        chk("dec_done_after_b", 32'(early_done), 32'd0);
        chk("dec_err", 32'(ls_err), 32'd0);
        rmem[5] = d;
        m_last_ls = 1'b1;
        ls_req = 1'b0; dec_mode = 1'b0;
        @(negedge clk);
        txn(1'b1, 1'b0, 32'd20, '0, '0, 3, got);
        chk("dec_readback", got, d);

        rresp_cfg = 2'b10;
        txn(1'b0, 1'b0, 32'd12, '0, '0, 3, got);
        rresp_cfg = 2'b00;

        for (int i = 0; i < 30; i++) begin
            kind = int'($urandom_range(0, 2));
            idx  = 4'($urandom_range(0, 15));
            lo   = 2'($urandom_range(0, 3));
            d    = $urandom;
            s    = 4'($urandom_range(0, 15));
            if (kind == 0)      txn(1'b1, 1'b0, {26'd0, idx, lo}, '0, '0, 3, got);
            else if (kind == 1) txn(1'b0, 1'b0, {26'd0, idx, lo}, '0, '0, 3, got);
            else                txn(1'b0, 1'b1, {26'd0, idx, lo}, d, s, 3, got);
        end

        // Reset while the read address is outstanding
        if_req = 1'b1; if_addr = 32'd4;
        @(negedge clk);
        chk("mid_pre_arvalid", 32'(arvalid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ar_r", 32'({arvalid, rready}), 32'h0);
        chk("mid_rst_done", 32'({if_done, ls_done}), 32'h0);
        if_req = 1'b0;
        bad_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (if_done || ls_done) bad_done = 1'b1;
        end
        chk("mid_rst_no_done", 32'(bad_done), 32'd0);
        rst_n = 1'b1;
        m_last_ls = 1'b1;
        @(negedge clk);
        txn(1'b1, 1'b0, 32'd4, '0, '0, 3, got);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester front end for the core's AXI-Lite memory slave. It accepts single-beat requests from the instruction-fetch unit (read only) and the load/store unit (read or write), and arbitrates between them round-robin. It runs one AXI-Lite transaction at a time on the shared master port and returns data and completion to the requester that was granted. It sits between the core pipeline and the memory slave; it is the only master on that bus.

## Interface
- AXI_AWIDTH, 32: address width on the requester ports and the AXI port.
- AXI_DWIDTH, 32: data width; the strobe width is AXI_DWIDTH/8.
- AXI_ACLK  in  1  sole clock, rising edge.
- AXI_ARESETN  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held high until if_done.
- if_addr  in  AXI_AWIDTH  fetch address; stable while if_req is high.
- if_rdata  out  AXI_DWIDTH  fetched word; valid while if_done is high.
- if_done  out  1  one-cycle completion pulse for fetch.
- ls_req  in  1  load/store request; held high until ls_done.
- ls_we  in  1  1 = write, 0 = read; stable while ls_req is high.
- ls_addr  in  AXI_AWIDTH  load/store address.
- ls_wdata  in  AXI_DWIDTH  store data.
- ls_wstrb  in  AXI_DWIDTH/8  store byte enables.
- ls_rdata  out  AXI_DWIDTH  load data; valid while ls_done is high.
- ls_done  out  1  one-cycle completion pulse for load/store.
- ls_err  out  1  qualifies ls_done: high if RRESP or BRESP ≠ 2'b00.
- if_err  out  1  qualifies if_done: high if RRESP ≠ 2'b00.
- AXI master port: AWADDR, AWVALID, AWREADY, WDATA, WSTRB, WVALID, WREADY, BRESP, BVALID, BREADY, ARADDR, ARVALID, ARREADY, RDATA, RRESP, RVALID, RREADY. All signals use the AXI_ prefix; widths and directions complement the memory slave.

## Operation
- FSM states: IDLE, READ, WRITE, RESP.
- **IDLE**
  - When neither request is high, stay in IDLE.
  - When exactly one request is high, grant it.
  - When both are high, grant the requester that is not last_grant.
  - last_grant resets to LS, so IF wins the first tie.
  - On a grant, update last_grant and latch address, write data, strobe and write flag.
  - A read grant goes to READ; a write grant goes to WRITE.
- **READ**
  - Drive ARVALID=1 and RREADY=1 with ARADDR equal to the latched address.
  - Track an ar_ok flag, set when ARVALID & ARREADY is sampled.
  - The read completes when RVALID & RREADY is sampled and either ar_ok is set or ARREADY is high in the same cycle.
  - On completion: drop ARVALID and RREADY, register RDATA into the granted rdata output, set err = (RRESP≠0), and go to RESP.
- **WRITE**
  - Drive AWVALID, WVALID and BREADY all high.
  - AWVALID drops after its handshake; WVALID drops after its handshake. The two are independent.
  - The write completes when BVALID is sampled with both AW and W handshakes done, either earlier or in the same cycle.
  - On completion: drop all three signals, set err = (BRESP≠0), and go to RESP.
- **RESP**
  - Pulse the granted done (and err) for one cycle, then return to IDLE.
  - The requester drops req in that same cycle; a still-high req in the next IDLE is treated as a new request.
- The non-granted requester waits; its request is never dropped or reordered.
- An LS write drives WSTRB = ls_wstrb. For IF, or for a read, WDATA and WSTRB are don't-care and WVALID = 0.
- Addresses are passed through unmodified; the slave ignores bits [1:0].

## Timing
- **Reset values**
  - All VALID/READY outputs: 0.
  - if_done, ls_done, if_err, ls_err: 0.
  - if_rdata, ls_rdata, AWADDR, ARADDR, WDATA: 0.
  - WSTRB: 0.
  - State: IDLE. last_grant: LS.
- **Read latency** against the memory slave, where the slave responds with ARREADY and RVALID together one cycle after it sees ARVALID & RREADY:
  - Req sampled at edge E0.
  - ARVALID high from E0 to E2.
  - done high from E2 to E3.
  - Total: 3 cycles from grant edge to done.
- **Write latency**: identical (AWREADY, WREADY and BVALID arrive together), so 3 cycles.
- Back-to-back operation: at least one IDLE cycle separates transactions, giving a minimum of 4 cycles per transaction.
- All outputs are registered; there are no combinational paths from requester inputs to AXI outputs.
- Reset asserted mid-transaction: all outputs return to reset values immediately (asynchronously) and no done pulse is issued.

## Test plan
- **IF read:** load memory word 1 with 32'h00500093; assert if_req with if_addr=4. Required: if_done high exactly 3 cycles after the grant edge, if_rdata=32'h00500093, if_err=0, ARVALID low the cycle after.
- **LS write then read:** write ls_wdata=32'hAABBCCDD with ls_wstrb=4'b0101 to address 8 over prior contents 32'h0; then read address 8. Required: ls_rdata=32'h00BB00DD.
- **Simultaneous requests, three rounds:** if_req and ls_req both held continuously. Required grant order IF, LS, IF; each requester gets exactly one done per transaction.
- **Decoupled write channels:** a slave model returns AWREADY 2 cycles before WREADY and BVALID. Required: AWVALID drops after its handshake while WVALID stays high; ls_done fires only after BVALID.
- **Error response:** slave returns RRESP=2'b10. Required: ls_done=1 and ls_err=1 in the same cycle.
- **Reset mid-read:** deassert AXI_ARESETN while ARVALID is high. Required: ARVALID=0 and RREADY=0 immediately with no done pulse; after release, a new if_req completes normally.
